wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning the width of every data port.
REQ-002 The block SHALL have port clk, input, 1, meaning the rising-edge clock; all state updates on posedge.
REQ-003 The block SHALL have port reset, input, 1, meaning reset, synchronous, active-low.
REQ-004 The block SHALL have ports alu_valid input 1, alu_ready output 1, alu_addr input 4, alu_data input DATA_W, meaning the ALU write-back request.
REQ-005 The block SHALL have ports mem_valid input 1, mem_ready output 1, mem_addr input 4, mem_data input DATA_W, meaning the load write-back request.
REQ-006 The block SHALL have ports md_valid input 1, md_ready output 1, md_addr input 4, md_data input DATA_W, md_r0 input DATA_W, meaning the mul/div dual write-back request (dest plus R0).
REQ-007 The block SHALL have ports regWrite output 2, FWriteback output 4, dataW output DATA_W, R0 output DATA_W, meaning the register-file write port, sampled by the register file on negedge.
REQ-008 The block SHALL have port busy, output 1, meaning an entry is pending or a write is being driven.

Function
REQ-009 Each source SHALL own a one-entry holding register; x_ready SHALL equal NOT(pending_x) while reset is high.
REQ-010 A request SHALL be accepted at a posedge where x_valid and x_ready are both 1; addr/data (and md_r0) SHALL be captured and pending_x set.
REQ-011 At each posedge the block SHALL grant at most one pending entry, clear its pending bit, and register the write outputs; an entry accepted at edge N SHALL be granted no earlier than edge N+1.
REQ-012 Arbitration SHALL be round-robin over ALU -> MEM -> MD; the search starts at the source after the last granted one; the pointer SHALL advance only on a grant.
REQ-013 An ALU/MEM grant SHALL drive regWrite=1, FWriteback=addr, dataW=data, R0 unchanged.
REQ-014 An MD grant SHALL drive regWrite=2, FWriteback=md_addr, dataW=md_data, R0=md_r0.
REQ-015 An MD entry with md_addr=0 SHALL be issued unchanged as regWrite=2 (dataW has priority for R0 in the register file).
REQ-016 A cycle without grant SHALL drive regWrite=0 and SHALL hold FWriteback, dataW and R0 at their last values, so register-file forwarding returns already-written data.
REQ-017 A source whose pending bit clears at edge N SHALL see x_ready=1 after edge N and may be accepted at edge N+1 (max one request per source per two cycles).
REQ-018 busy SHALL equal (any pending) OR (regWrite != 0).
REQ-019 With ordering enabled (REQ-025), each entry SHALL carry age bits versus the other two; an entry SHALL not be granted while an older pending entry targets the same register (MD counts as targeting md_addr and register 0).
REQ-020 On same-edge acceptance, age SHALL be MD older than MEM older than ALU.
REQ-021 When no eligible entry exists at the round-robin start point, the next eligible source in rotation SHALL be granted; an older conflicting entry is always eligible, so no deadlock.

Reset
REQ-022 While reset=0 at a posedge: all pending bits cleared (in-flight entries discarded), pointer set so ALU is searched first, age bits cleared, regWrite=0, FWriteback=0, dataW=0, R0=0.
REQ-023 While reset=0, alu_ready, mem_ready and md_ready SHALL be 0 and busy SHALL be 0 after the reset edge.
REQ-024 The first edge with reset=1 SHALL be able to accept requests; grants start on the following edge.

Configuration
REQ-025 Macro WB_ARB_ORDER_CHECK_EN defined: same-destination ordering per REQ-019..REQ-021 is compiled in.
REQ-026 Macro WB_ARB_ORDER_CHECK_EN undefined: age logic is absent, arbitration is pure round-robin per REQ-012, and all other behaviour is unchanged.

Verification
REQ-027 Reset then idle: reset=0 for 2 cycles -> regWrite=0, FWriteback=0, dataW=0, all ready=0; release -> all ready=1, busy=0.
REQ-028 Single ALU request alu_addr=5, alu_data=16'h1234 accepted at edge 1 -> after edge 2 regWrite=1, FWriteback=5, dataW=16'h1234; after edge 3 regWrite=0, FWriteback=5 held.
REQ-029 All three valid at the same edge, distinct addresses 3/4/6, md_r0=16'hBEEF -> grants ALU, MEM, MD on the next three edges; MD cycle shows regWrite=2, R0=16'hBEEF.
REQ-030 With WB_ARB_ORDER_CHECK_EN: MEM addr=7 accepted at edge 1, then ALU addr=7 at edge 2 with the pointer favouring ALU -> MEM data written first, then ALU data; without the macro -> round-robin order.
REQ-031 Reset asserted while MEM and MD are pending -> no write issued after the reset edge, regWrite=0, pending cleared, ready=1 after release.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Round-robin write-back arbiter: ALU/MEM/MD one-entry holders onto one register-file port, 1 edge accept-to-write; x_ready low while its entry is held.
// Macro WB_ARB_ORDER_CHECK_EN keeps same-destination writes in acceptance order.
module wb_port_arbiter #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [3:0]        alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [3:0]        mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              md_valid,
  output logic              md_ready,
  input  logic [3:0]        md_addr,
  input  logic [DATA_W-1:0] md_data,
  input  logic [DATA_W-1:0] md_r0,
  output logic [1:0]        regWrite,
  output logic [3:0]        FWriteback,
  output logic [DATA_W-1:0] dataW,
  output logic [DATA_W-1:0] R0,
  output logic              busy
);
  localparam int MD = 2;

  logic [2:0]        pend_q, pend_d, acc, elig, grant;
  logic [1:0]        ptr_q, ptr_d, gsel, rr_idx;
  logic              found;
  logic [3:0]        addr_q [3];
  logic [DATA_W-1:0] data_q [3];
  logic [DATA_W-1:0] r0_q;
  logic [1:0]        wr_kind_q;
  logic [3:0]        wr_addr_q;
  logic [DATA_W-1:0] wr_data_q, wr_r0_q;

  assign alu_ready = reset & ~pend_q[0];
  assign mem_ready = reset & ~pend_q[1];
  assign md_ready  = reset & ~pend_q[2];
  assign acc = {md_valid & md_ready, mem_valid & mem_ready, alu_valid & alu_ready};

`ifdef WB_ARB_ORDER_CHECK_EN
  // older_q[i][j]: entry i was accepted before entry j
  logic [2:0] older_q [3];
  logic [2:0] older_d [3];

  always_comb begin
    elig = pend_q;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (i != j && pend_q[j] && older_q[j][i] &&
            ((addr_q[i] == addr_q[j]) || (i == MD && addr_q[j] == 4'd0) ||
             (j == MD && addr_q[i] == 4'd0)))
          elig[i] = 1'b0;
      end
    end
  end

  // Same-edge arrivals rank MD oldest, then MEM, then ALU (higher index is older).
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      older_d[i] = older_q[i];
      for (int j = 0; j < 3; j++) begin
        if (i != j) begin
          if (acc[i])      older_d[i][j] = acc[j] && (i > j);
          else if (acc[j]) older_d[i][j] = pend_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset) older_q[i] <= 3'b000;
      else        older_q[i] <= older_d[i];
    end
  end
`else
  assign elig = pend_q;
`endif

  always_comb begin
    found  = 1'b0;
    gsel   = 2'd0;
    rr_idx = 2'd0;
    for (int k = 0; k < 3; k++) begin
      rr_idx = 2'((int'(ptr_q) + k) % 3);
      if (!found && elig[rr_idx]) begin
        found = 1'b1;
        gsel  = rr_idx;
      end
    end
    grant  = found ? (3'b001 << gsel) : 3'b000;
    pend_d = (pend_q & ~grant) | acc;
    ptr_d  = ptr_q;
    if (found) ptr_d = (gsel == 2'd2) ? 2'd0 : gsel + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_q    <= 3'b000;
      ptr_q     <= 2'd0;
      wr_kind_q <= 2'd0;
      wr_addr_q <= 4'd0;
      wr_data_q <= '0;
      wr_r0_q   <= '0;
    end else begin
      pend_q <= pend_d;
      ptr_q  <= ptr_d;
      if (found) begin
        wr_kind_q <= (gsel == 2'd2) ? 2'd2 : 2'd1;
        wr_addr_q <= addr_q[gsel];
        wr_data_q <= data_q[gsel];
        if (gsel == 2'd2) wr_r0_q <= r0_q;
      end else begin
        // Address/data held so register-file forwarding sees the last write.
        wr_kind_q <= 2'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc[0]) begin
      addr_q[0] <= alu_addr;
      data_q[0] <= alu_data;
    end
    if (acc[1]) begin
      addr_q[1] <= mem_addr;
      data_q[1] <= mem_data;
    end
    if (acc[2]) begin
      addr_q[2] <= md_addr;
      data_q[2] <= md_data;
      r0_q      <= md_r0;
    end
  end

  assign regWrite   = wr_kind_q;
  assign FWriteback = wr_addr_q;
  assign dataW      = wr_data_q;
  assign R0         = wr_r0_q;
  assign busy       = (|pend_q) | (wr_kind_q != 2'd0);
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus random traffic against a timestamp-based reference model.
module tb_wb_port_arbiter;
`ifdef WB_ARB_ORDER_CHECK_EN
  localparam bit ORDER = 1'b1;
`else
  localparam bit ORDER = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        alu_valid, mem_valid, md_valid;
  logic        alu_ready, mem_ready, md_ready;
  logic [3:0]  alu_addr, mem_addr, md_addr, FWriteback;
  logic [15:0] alu_data, mem_data, md_data, md_r0, dataW, R0;
  logic [1:0]  regWrite;
  logic        busy;

  wb_port_arbiter #(.DATA_W(16)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .md_valid(md_valid), .md_ready(md_ready), .md_addr(md_addr), .md_data(md_data), .md_r0(md_r0),
    .regWrite(regWrite), .FWriteback(FWriteback), .dataW(dataW), .R0(R0), .busy(busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: entries ordered by acceptance timestamp
  bit          m_pend [3];
  int          m_addr [3];
  logic [15:0] m_data [3];
  int          m_seq  [3];
  logic [15:0] m_r0;
  int          seq_ctr = 0;
  int          m_ptr = 0;
  int          m_rw = 0, m_fw = 0;
  logic [15:0] m_dw = '0, m_r0out = '0;

  function automatic bit m_targets(input int src, input int r);
    if (src == 2) return (r == m_addr[2]) || (r == 0);
    return r == m_addr[src];
  endfunction

  function automatic bit m_conflict(input int i, input int j);
    for (int r = 0; r < 16; r++)
      if (m_targets(i, r) && m_targets(j, r)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_eligible(input int i);
    if (!m_pend[i]) return 1'b0;
    if (ORDER)
      for (int j = 0; j < 3; j++)
        if (j != i && m_pend[j] && m_seq[j] < m_seq[i] && m_conflict(i, j)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    bit acc [3];
    int g;
    if (!reset) begin
      for (int i = 0; i < 3; i++) m_pend[i] = 1'b0;
      m_ptr = 0; m_rw = 0; m_fw = 0; m_dw = '0; m_r0out = '0;
      return;
    end
    acc[0] = alu_valid && !m_pend[0];
    acc[1] = mem_valid && !m_pend[1];
    acc[2] = md_valid  && !m_pend[2];
    g = -1;
    for (int k = 0; k < 3; k++)
      if (g < 0 && m_eligible((m_ptr + k) % 3)) g = (m_ptr + k) % 3;
    if (g >= 0) begin
      m_pend[g] = 1'b0;
      m_ptr = (g + 1) % 3;
      m_rw = (g == 2) ? 2 : 1;
      m_fw = m_addr[g];
      m_dw = m_data[g];
      if (g == 2) m_r0out = m_r0;
    end else begin
      m_rw = 0;
    end
    if (acc[2]) begin m_pend[2] = 1'b1; m_addr[2] = int'(md_addr);  m_data[2] = md_data;  m_r0 = md_r0; m_seq[2] = seq_ctr++; end
    if (acc[1]) begin m_pend[1] = 1'b1; m_addr[1] = int'(mem_addr); m_data[1] = mem_data; m_seq[1] = seq_ctr++; end
    if (acc[0]) begin m_pend[0] = 1'b1; m_addr[0] = int'(alu_addr); m_data[0] = alu_data; m_seq[0] = seq_ctr++; end
  endtask

  task automatic cycle(input bit rst_v, input bit [2:0] v,
                       input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2,
                       input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                       input logic [15:0] r0v);
    reset = rst_v;
    alu_valid = v[0]; mem_valid = v[1]; md_valid = v[2];
    alu_addr = a0; mem_addr = a1; md_addr = a2;
    alu_data = d0; mem_data = d1; md_data = d2; md_r0 = r0v;
    #1;
    check("alu_ready", alu_ready, rst_v && !m_pend[0]);
    check("mem_ready", mem_ready, rst_v && !m_pend[1]);
    check("md_ready",  md_ready,  rst_v && !m_pend[2]);
    @(posedge clk);
    model_edge();
    #1;
    check("regWrite",   regWrite,   m_rw);
    check("FWriteback", FWriteback, m_fw);
    check("dataW",      dataW,      m_dw);
    check("R0",         R0,         m_r0out);
    check("busy",       busy,       (m_pend[0] || m_pend[1] || m_pend[2] || m_rw != 0));
  endtask

  task automatic idle(input bit rst_v);
    cycle(rst_v, 3'b000, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0, 16'h0);
  endtask

  initial begin
    // Reset then idle
    idle(1'b0);
    idle(1'b0);
    check("rst_regWrite", regWrite, 0);
    check("rst_FWriteback", FWriteback, 0);
    check("rst_dataW", dataW, 0);
    check("rst_ready", {alu_ready, mem_ready, md_ready}, 3'b000);

    // Single ALU request
    cycle(1'b1, 3'b001, 4'd5, 4'd0, 4'd0, 16'h1234, 16'h0, 16'h0, 16'h0);
    check("single_busy", busy, 1);
    idle(1'b1);
    check("single_rw", regWrite, 1);
    check("single_fw", FWriteback, 5);
    check("single_dw", dataW, 16'h1234);
    idle(1'b1);
    check("single_rw_idle", regWrite, 0);
    check("single_fw_held", FWriteback, 5);

    // Three simultaneous requests
    idle(1'b0);
    cycle(1'b1, 3'b111, 4'd3, 4'd4, 4'd6, 16'h1111, 16'h2222, 16'h3333, 16'hBEEF);
    idle(1'b1);
    check("rr_alu_fw", FWriteback, 3);
    idle(1'b1);
    check("rr_mem_fw", FWriteback, 4);
    idle(1'b1);
    check("rr_md_fw", FWriteback, 6);
    check("rr_md_rw", regWrite, 2);
    check("rr_md_r0", R0, 16'hBEEF);

    // Same destination: older MEM vs newer ALU with pointer at ALU
    idle(1'b0);
    cycle(1'b1, 3'b010, 4'd0, 4'd2, 4'd0, 16'h0, 16'h5555, 16'h0, 16'h0);
    idle(1'b1);
    cycle(1'b1, 3'b110, 4'd0, 4'd7, 4'd9, 16'h0, 16'hAAAA, 16'hCCCC, 16'h7777);
    cycle(1'b1, 3'b001, 4'd7, 4'd0, 4'd0, 16'hBBBB, 16'h0, 16'h0, 16'h0);
    check("ord_md_rw", regWrite, 2);
    idle(1'b1);
    check("ord_first", dataW, ORDER ? 16'hAAAA : 16'hBBBB);
    idle(1'b1);
    check("ord_second", dataW, ORDER ? 16'hBBBB : 16'hAAAA);

    // Reset while MEM and MD pending
    idle(1'b0);
    cycle(1'b1, 3'b110, 4'd0, 4'd1, 4'd2, 16'h0, 16'h4444, 16'h6666, 16'h8888);
    idle(1'b0);
    check("rst_pend_rw", regWrite, 0);
    check("rst_pend_busy", busy, 0);
    idle(1'b1);
    check("rst_pend_ready", {alu_ready, mem_ready, md_ready}, 3'b111);
    check("rst_pend_nowrite", regWrite, 0);

    // Random traffic, small address range to provoke conflicts
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 99) != 0), 3'($urandom_range(0, 7)),
            4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
